// File: rtl/dma_resp_pkg.sv
// Shared types and constants for the DMA memory responder.
// Holds channel FSM states, the beat geometry and the burst length type.
package dma_resp_pkg;

    localparam int unsigned BEAT_BYTES = 64;

    typedef logic [7:0] len_t;

    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_e;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;

    // Width of a beat index for a memory of 2**depth_log2 beats.
    function automatic int unsigned beat_idx_w(input int unsigned depth_log2);
        return (depth_log2 == 0) ? 1 : depth_log2;
    endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// Host DMA read/write bus between the decompressor (master) and the memory responder (slave).
interface dma_mem_responder_if #(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512
);
    import dma_resp_pkg::*;

    logic                          dma_rd_req;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dma_rd_addr;
    len_t                          dma_rd_len;
    logic                          dma_rd_req_ack;
    logic [C_M_AXI_DATA_WIDTH-1:0] dma_rd_data;
    logic                          dma_rd_data_valid;
    logic                          dma_rd_data_taken;

    logic                          dma_wr_req;
    logic [C_M_AXI_ADDR_WIDTH-1:0] dma_wr_addr;
    len_t                          dma_wr_len;
    logic                          dma_wr_req_ack;
    logic [C_M_AXI_DATA_WIDTH-1:0] dma_wr_data;
    logic                          dma_wr_wvalid;
    logic [BEAT_BYTES-1:0]         dma_wr_data_strobe;
    logic                          dma_wr_data_last;
    logic                          dma_wr_ready;
    logic                          dma_wr_bready;
    logic                          dma_wr_done;
    logic                          wr_last_err;

    modport master (
        output dma_rd_req, dma_rd_addr, dma_rd_len, dma_rd_data_taken,
        output dma_wr_req, dma_wr_addr, dma_wr_len, dma_wr_data, dma_wr_wvalid,
        output dma_wr_data_strobe, dma_wr_data_last, dma_wr_bready,
        input  dma_rd_req_ack, dma_rd_data, dma_rd_data_valid,
        input  dma_wr_req_ack, dma_wr_ready, dma_wr_done, wr_last_err
    );

    modport slave (
        input  dma_rd_req, dma_rd_addr, dma_rd_len, dma_rd_data_taken,
        input  dma_wr_req, dma_wr_addr, dma_wr_len, dma_wr_data, dma_wr_wvalid,
        input  dma_wr_data_strobe, dma_wr_data_last, dma_wr_bready,
        output dma_rd_req_ack, dma_rd_data, dma_rd_data_valid,
        output dma_wr_req_ack, dma_wr_ready, dma_wr_done, wr_last_err
    );

endinterface

// File: rtl/dma_resp_ram.sv
// Dual-port beat memory: synchronous registered read port, byte-enabled write port.
// A same-cycle read and write to one beat returns the old contents.
module dma_resp_ram
    import dma_resp_pkg::*;
#(
    parameter int unsigned DATA_W = 512,
    parameter int unsigned IDX_W  = 10
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [IDX_W-1:0]      wr_idx,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [BEAT_BYTES-1:0] wr_be
);

    logic [DATA_W-1:0] mem [2**IDX_W];

    // Nonblocking update of both ports in one process gives read-first behaviour.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_idx];
        end
        if (wr_en) begin
            for (int i = 0; i < BEAT_BYTES; i++) begin
                if (wr_be[i]) begin
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/dma_mem_responder.sv
// Standalone responder for the host DMA bus: independent read and write FSMs
// serving bursts from an on-chip beat memory, plus a write last-flag checker.
module dma_mem_responder
    import dma_resp_pkg::*;
#(
    parameter int unsigned C_M_AXI_ADDR_WIDTH = 64,
    parameter int unsigned C_M_AXI_DATA_WIDTH = 512,
    parameter int unsigned MEM_DEPTH_LOG2     = 10
) (
    input logic              clk,
    input logic              rst_n,
    dma_mem_responder_if.slave dma
);

    localparam int unsigned IDX_W = beat_idx_w(MEM_DEPTH_LOG2);
    typedef logic [IDX_W-1:0] idx_t;

    rd_state_e rd_state_q, rd_state_d;
    logic      rd_ack_q, rd_ack_d;
    idx_t      rd_idx_q, rd_idx_d;
    len_t      rd_len_q, rd_len_d;
    len_t      rd_cnt_q, rd_cnt_d;
    logic      rd_fetch;

    wr_state_e wr_state_q, wr_state_d;
    logic      wr_ack_q, wr_ack_d;
    idx_t      wr_idx_q, wr_idx_d;
    len_t      wr_len_q, wr_len_d;
    len_t      wr_cnt_q, wr_cnt_d;
    logic      wr_err_q, wr_err_d;
    logic      wr_accept;

    logic [C_M_AXI_DATA_WIDTH-1:0] ram_rd_data;

    // Only the beat index bits of the byte addresses are meaningful.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{dma.dma_rd_addr[5:0], dma.dma_rd_addr[C_M_AXI_ADDR_WIDTH-1:IDX_W+6],
                                dma.dma_wr_addr[5:0], dma.dma_wr_addr[C_M_AXI_ADDR_WIDTH-1:IDX_W+6]};

    // Read channel. IDLE holds for the ack cycle so valid lands three cycles after req.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ack_d   = 1'b0;
        rd_idx_d   = rd_idx_q;
        rd_len_d   = rd_len_q;
        rd_cnt_d   = rd_cnt_q;
        rd_fetch   = 1'b0;
        unique case (rd_state_q)
            R_IDLE: begin
                if (rd_ack_q) begin
                    rd_state_d = R_FETCH;
                end else if (dma.dma_rd_req) begin
                    rd_ack_d = 1'b1;
                    rd_idx_d = dma.dma_rd_addr[IDX_W+5:6];
                    rd_len_d = dma.dma_rd_len;
                    rd_cnt_d = '0;
                end
            end
            R_FETCH: begin
                rd_fetch   = 1'b1;
                rd_state_d = R_DATA;
            end
            R_DATA: begin
                if (dma.dma_rd_data_taken) begin
                    if (rd_cnt_q == rd_len_q) begin
                        rd_state_d = R_IDLE;
                    end else begin
                        rd_idx_d   = rd_idx_q + idx_t'(1);
                        rd_cnt_d   = rd_cnt_q + len_t'(1);
                        rd_state_d = R_FETCH;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_state_q <= R_IDLE;
            rd_ack_q   <= 1'b0;
            rd_idx_q   <= '0;
            rd_len_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            rd_ack_q   <= rd_ack_d;
            rd_idx_q   <= rd_idx_d;
            rd_len_q   <= rd_len_d;
            rd_cnt_q   <= rd_cnt_d;
        end
    end

    // Write channel. Sequencing follows the latched length; last is only checked.
    always_comb begin
        wr_state_d = wr_state_q;
        wr_ack_d   = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_len_d   = wr_len_q;
        wr_cnt_d   = wr_cnt_q;
        wr_err_d   = wr_err_q;
        wr_accept  = 1'b0;
        unique case (wr_state_q)
            W_IDLE: begin
                if (wr_ack_q) begin
                    wr_state_d = W_DATA;
                end else if (dma.dma_wr_req) begin
                    wr_ack_d = 1'b1;
                    wr_idx_d = dma.dma_wr_addr[IDX_W+5:6];
                    wr_len_d = dma.dma_wr_len;
                    wr_cnt_d = '0;
                end
            end
            W_DATA: begin
                if (dma.dma_wr_wvalid) begin
                    wr_accept = 1'b1;
                    wr_idx_d  = wr_idx_q + idx_t'(1);
                    wr_cnt_d  = wr_cnt_q + len_t'(1);
                    if (dma.dma_wr_data_last != (wr_cnt_q == wr_len_q)) begin
                        wr_err_d = 1'b1;
                    end
                    if (wr_cnt_q == wr_len_q) begin
                        wr_state_d = W_RESP;
                    end
                end
            end
            W_RESP: begin
                if (dma.dma_wr_bready) begin
                    wr_state_d = W_IDLE;
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_state_q <= W_IDLE;
            wr_ack_q   <= 1'b0;
            wr_idx_q   <= '0;
            wr_len_q   <= '0;
            wr_cnt_q   <= '0;
            wr_err_q   <= 1'b0;
        end else begin
            wr_state_q <= wr_state_d;
            wr_ack_q   <= wr_ack_d;
            wr_idx_q   <= wr_idx_d;
            wr_len_q   <= wr_len_d;
            wr_cnt_q   <= wr_cnt_d;
            wr_err_q   <= wr_err_d;
        end
    end

    dma_resp_ram #(
        .DATA_W (C_M_AXI_DATA_WIDTH),
        .IDX_W  (IDX_W)
    ) u_ram (
        .clk     (clk),
        .rd_en   (rd_fetch),
        .rd_idx  (rd_idx_q),
        .rd_data (ram_rd_data),
        .wr_en   (wr_accept),
        .wr_idx  (wr_idx_q),
        .wr_data (dma.dma_wr_data),
        .wr_be   (dma.dma_wr_data_strobe)
    );

    assign dma.dma_rd_req_ack    = rd_ack_q;
    assign dma.dma_rd_data_valid = (rd_state_q == R_DATA);
    // RAM output register is not reset, so mask it outside a valid beat.
    assign dma.dma_rd_data       = (rd_state_q == R_DATA) ? ram_rd_data : '0;
    assign dma.dma_wr_req_ack    = wr_ack_q;
    assign dma.dma_wr_ready      = (wr_state_q == W_DATA);
    assign dma.dma_wr_done       = (wr_state_q == W_RESP);
    assign dma.wr_last_err       = wr_err_q;

endmodule

// File: doc/dma_mem_responder.md
# dma_mem_responder

Responder end of the host DMA read/write interface that the decompressor top level drives. It serves `dma_rd_*` burst reads and `dma_wr_*` burst writes out of an on-chip, byte-enabled, dual-port memory. This lets the decompressor plus io_control be run standalone in simulation or on-FPGA self-test, without a host shell. The read and write channels are independent FSMs sharing one memory.

## Interface

Parameters:
- `C_M_AXI_ADDR_WIDTH`, 64: byte address width.
- `C_M_AXI_DATA_WIDTH`, 512: beat width. Fixed at 64 bytes per beat.
- `MEM_DEPTH_LOG2`, 10: log2 of the memory depth in beats.

Ports (clock and reset first):
- `clk`  in  1  sole clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `dma_rd_req`  in  1  read request; held high until acked.
- `dma_rd_addr`  in  ADDR  read start byte address.
- `dma_rd_len`  in  8  read burst length, encoded as beats-1.
- `dma_rd_req_ack`  out  1  one-cycle read request accept pulse.
- `dma_rd_data`  out  DATA  read beat.
- `dma_rd_data_valid`  out  1  read beat valid.
- `dma_rd_data_taken`  in  1  requester ready to take a read beat.
- `dma_wr_req`  in  1  write request; held high until acked.
- `dma_wr_addr`  in  ADDR  write start byte address.
- `dma_wr_len`  in  8  write burst length, encoded as beats-1.
- `dma_wr_req_ack`  out  1  one-cycle write request accept pulse.
- `dma_wr_data`  in  DATA  write beat.
- `dma_wr_wvalid`  in  1  write beat valid.
- `dma_wr_data_strobe`  in  64  byte enables; bit i enables `dma_wr_data[8i+7:8i]`.
- `dma_wr_data_last`  in  1  marks the final write beat.
- `dma_wr_ready`  out  1  write channel accepting beats.
- `dma_wr_bready`  in  1  requester accepts the write response.
- `dma_wr_done`  out  1  write response valid.
- `wr_last_err`  out  1  sticky: last/count mismatch seen.

## Operation

- Address mapping:
  - Beat index = `addr[MEM_DEPTH_LOG2+5:6]`. Bits [5:0] are ignored, so addresses are treated as 64-byte aligned.
  - The index increments by 1 per beat and wraps modulo 2^MEM_DEPTH_LOG2.
  - Beats per burst = len+1, so a burst is 1..256 beats. The beat counter is 8 bits, compared against the latched len.
- Read FSM, states R_IDLE, R_FETCH, R_DATA:
  - R_IDLE: if `dma_rd_req`, pulse `dma_rd_req_ack` on the next cycle, latch addr and len, then go to R_FETCH.
  - R_FETCH: issue the synchronous RAM read (1-cycle latency), then go to R_DATA.
  - R_DATA: `dma_rd_data_valid`=1. Data is held stable until `valid && dma_rd_data_taken`.
  - On a take: if count==len go to R_IDLE; otherwise increment the index and count and go to R_FETCH.
- Write FSM, states W_IDLE, W_DATA, W_RESP:
  - W_IDLE: if `dma_wr_req`, pulse `dma_wr_req_ack` on the next cycle, latch addr and len, then go to W_DATA.
  - W_DATA: `dma_wr_ready`=1. On `wvalid && ready`, write the beat with byte enables = strobe, then increment the index and count.
  - Leaving W_DATA: when the beat with count==len is accepted, go to W_RESP.
  - Last checking: `wr_last_err` is set if `dma_wr_data_last` differs from (count==len) on any accepted beat. The FSM ignores `last` for sequencing.
  - W_RESP: `dma_wr_done`=1 until `dma_wr_bready`, then go to W_IDLE.
- Channels run concurrently. When a write and a read fetch hit the same beat in the same cycle, the read returns the old data (read-first).
- Requests are sampled only in the IDLE state of their channel. A request that arrives while the channel is busy waits until the channel returns to IDLE.

## Timing

- Reset values: every output is 0, both FSMs are in IDLE, and `wr_last_err`=0. Memory contents are not reset.
- Reset mid-burst aborts the burst immediately. No partial response is issued.
- Read latency:
  - req high at cycle t → ack at t+1 → valid at t+3.
  - After a take at cycle u, the next valid is at u+2. Reads therefore sustain at most 1 beat per 2 cycles.
- Write throughput: 1 beat per cycle.
  - ack at t+1 → ready at t+2.
  - Final beat accepted at v → `dma_wr_done` at v+1.
  - done held with bready high at w → done=0 and ready for a new request at w+1. The next ack comes no earlier than w+2.
- Ack is registered, exactly one cycle wide, and never asserted outside IDLE.
- A request deasserting before its ack is a protocol violation and is not checked.

## Structure

- Package `dma_resp_pkg`:
  - read and write state enums;
  - `BEAT_BYTES`=64;
  - the beat-index width function;
  - the len/count typedef (8 bits).
- Sub-module `dma_resp_ram`: a true dual-port RAM. The read port is synchronous with registered output. The write port has 64 byte enables. Read-first on a same-address collision.
- Top level: two FSMs, the address/count registers, and the last checker.

## Test plan

- Read single beat: preload beat 5 with pattern P; read addr 0x140, len 0, taken held high → ack at t+1, one valid beat = P at t+3, then valid=0.
- Read backpressure: read len 3, taken toggling 1-0-0-1 → each beat held stable until taken; 4 beats in address order; no duplicates or drops.
- Write with strobe, then read back: write len 1 to addr 0, beat 0 strobe 0x0F, beat 1 strobe all ones → done 1 cycle after beat 1. Readback shows only bytes 0-3 updated in beat 0 and all of beat 1 updated.
- Wrap-around: with MEM_DEPTH_LOG2=4, write len 3 at beat 14 → beats land at 14, 15, 0, 1.
- Response hold and last error:
  - bready held low for 5 cycles → done stays high and a new write req is not acked.
  - `last` asserted on beat 0 of a len-2 burst → `wr_last_err`=1 and stays sticky.
- Concurrency and reset:
  - Simultaneous read and write to the same beat → read returns the old data.
  - `rst_n` low mid-read-burst → valid=0 asynchronously; the next request is served normally.
